// File: rtl/div255_pkg.sv
// Shared types and constants for the divide-by-255 result checker.
package div255_pkg;

  localparam int unsigned HALF_W_DEFAULT = 16;
  localparam int unsigned DIV_K          = 255;
  localparam int unsigned REM_MAX        = DIV_K - 1;

  typedef enum logic [2:0] {
    StIdle,
    StGetHi,
    StGetLo,
    StCalc1,
    StCalc2,
    StOut
  } state_e;

endpackage

// File: rtl/div255_result_checker_if.sv
// Request/result bundle between the divide-by-255 stage, the checker and its consumer.
interface div255_result_checker_if
  import div255_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEFAULT
) ();

  logic                  start;
  logic [2*HALF_W-1:0]   dividend;
  logic [HALF_W-1:0]     din;
  logic                  hi_vld;
  logic                  lo_vld;
  logic                  res_rdy;
  logic                  res_vld;
  logic [2*HALF_W-1:0]   q_out;
  logic [7:0]            rem_out;
  logic                  err;
  logic                  busy;

  modport master (
    output start, dividend, din, hi_vld, lo_vld, res_rdy,
    input  res_vld, q_out, rem_out, err, busy
  );

  modport slave (
    input  start, dividend, din, hi_vld, lo_vld, res_rdy,
    output res_vld, q_out, rem_out, err, busy
  );

endinterface

// File: rtl/mul255_sub.sv
// Combinational P = 255*Q and R = X - P datapath; the parent registers both.
module mul255_sub #(
  parameter int unsigned QW = 32
) (
  input  logic [QW-1:0] q,
  input  logic [QW-1:0] x,
  input  logic [QW+1:0] p_reg,
  output logic [QW+1:0] p,
  output logic [QW+1:0] r
);

  logic [QW+1:0] q_ext;
  logic [QW+1:0] x_ext;

  assign q_ext = {2'b00, q};
  assign x_ext = {2'b00, x};

  // 255*Q as shift-and-subtract, deliberately truncated to QW+2 bits.
  assign p = (q_ext << 8) - q_ext;
  assign r = x_ext - p_reg;

endmodule

// File: rtl/div255_result_checker.sv
// Checks a serial divide-by-255 quotient against its dividend (X - 255*Q in 0..254).
// Arithmetic is only built when DIV255_CHECK_EN is defined; otherwise rem_out/err read 0.
module div255_result_checker
  import div255_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEFAULT
) (
  input logic                    clk,
  input logic                    rst,
  div255_result_checker_if.slave bus
);

  localparam int unsigned QW = 2 * HALF_W;
  localparam int unsigned PW = QW + 2;

  state_e        state_q, state_d;
  logic [QW-1:0] x_q;
  logic [QW-1:0] q_q;
  logic          x_en, hi_en, lo_en, p_en, r_en;

  always_comb begin
    state_d = state_q;
    x_en    = 1'b0;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
    p_en    = 1'b0;
    r_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_en    = 1'b1;
          state_d = StGetHi;
        end
      end
      StGetHi: begin
        if (bus.hi_vld) begin
          hi_en   = 1'b1;
          state_d = StGetLo;
        end
      end
      StGetLo: begin
        if (bus.lo_vld) begin
          lo_en   = 1'b1;
          state_d = StCalc1;
        end
      end
      StCalc1: begin
        p_en    = 1'b1;
        state_d = StCalc2;
      end
      StCalc2: begin
        r_en    = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (bus.res_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      if (x_en)  x_q              <= bus.dividend;
      if (hi_en) q_q[QW-1:HALF_W] <= bus.din;
      if (lo_en) q_q[HALF_W-1:0]  <= bus.din;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.res_vld = (state_q == StOut);
  assign bus.q_out   = q_q;

`ifdef DIV255_CHECK_EN
  logic [PW-1:0] p_d, p_q;
  logic [PW-1:0] r_d, r_q;
  logic          r_neg, r_big;

  mul255_sub #(
    .QW(QW)
  ) u_mul255_sub (
    .q    (q_q),
    .x    (x_q),
    .p_reg(p_q),
    .p    (p_d),
    .r    (r_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      r_q <= '0;
    end else begin
      if (p_en) p_q <= p_d;
      if (r_en) r_q <= r_d;
    end
  end

  // r_q only changes in CALC2, so err/rem_out stay put throughout OUT.
  assign r_neg       = r_q[PW-1];
  assign r_big       = (r_q > PW'(REM_MAX));
  assign bus.err     = r_neg | r_big;
  assign bus.rem_out = bus.err ? 8'd0 : r_q[7:0];
`else
  logic unused_calc;
  assign unused_calc = ^{x_q, p_en, r_en};
  assign bus.err     = 1'b0;
  assign bus.rem_out = 8'd0;
`endif

endmodule

// File: tb/tb_div255_result_checker.sv
// Scoreboard bench for div255_result_checker; expectations follow DIV255_CHECK_EN.
module tb_div255_result_checker;
  import div255_pkg::*;

  localparam int unsigned HW = 16;
`ifdef DIV255_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic [7:0]  rem;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div255_result_checker_if #(.HALF_W(HW)) bus ();

  div255_result_checker #(
    .HALF_W(HW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [31:0] q_model;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R is a 34-bit two's-complement X - (255*Q truncated to 34 bits).
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] q);
    exp_t   e;
    longint mask34;
    longint p;
    longint r;
    mask34 = (longint'(1) << 34) - 1;
    p      = (longint'(q) * 255) & mask34;
    r      = (longint'(x) - p) & mask34;
    if (r >= (longint'(1) << 33)) r = r - (longint'(1) << 34);
    e.q   = q;
    e.err = 1'b0;
    e.rem = 8'd0;
    if (CHECK_EN) begin
      if (r < 0 || r > 254) e.err = 1'b1;
      else e.rem = r[7:0];
    end
    return e;
  endfunction

  task automatic compare_out(input string tag, input exp_t e);
    check_eq({tag, "_vld"}, bus.res_vld, 1'b1);
    check_eq({tag, "_q"}, bus.q_out, e.q);
    check_eq({tag, "_rem"}, bus.rem_out, e.rem);
    check_eq({tag, "_err"}, bus.err, e.err);
  endtask

  task automatic run_txn(input logic [31:0] x, input logic [15:0] hi, input logic [15:0] lo,
                         input int hold, input bit both_at_hi);
    exp_t e;
    int   n;
    bus.start    = 1'b1;
    bus.dividend = x;
    tick();
    check_eq("busy_after_start", bus.busy, 1'b1);
    // start and a different dividend while busy must be ignored
    bus.dividend = ~x;
    bus.din      = hi;
    bus.hi_vld   = 1'b1;
    bus.lo_vld   = both_at_hi;
    tick();
    bus.hi_vld = 1'b0;
    bus.lo_vld = 1'b0;
    q_model    = {hi, q_model[15:0]};
    check_eq("q_after_hi", bus.q_out, q_model);
    check_eq("vld_in_get_lo", bus.res_vld, 1'b0);
    bus.din    = lo;
    bus.lo_vld = 1'b1;
    bus.hi_vld = 1'b1;
    q_model    = {q_model[31:16], lo};
    sb.push_back(model(x, q_model));
    tick();
    bus.lo_vld = 1'b0;
    bus.hi_vld = 1'b0;
    bus.start  = 1'b0;
    // CALC1 and CALC2 follow the capture edge, then OUT
    n = 0;
    while (!bus.res_vld && n < 8) begin
      tick();
      n++;
    end
    check_eq("latency", n, 2);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      compare_out("out", e);
      for (int i = 0; i < hold; i++) begin
        tick();
        compare_out("hold", e);
      end
    end
    bus.res_rdy = 1'b1;
    tick();
    bus.res_rdy = 1'b0;
    check_eq("busy_after_rdy", bus.busy, 1'b0);
    check_eq("vld_after_rdy", bus.res_vld, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
    check_eq({tag, "_vld"}, bus.res_vld, 1'b0);
    check_eq({tag, "_q"}, bus.q_out, 32'd0);
    check_eq({tag, "_rem"}, bus.rem_out, 8'd0);
    check_eq({tag, "_err"}, bus.err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] q;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.din      = '0;
    bus.hi_vld   = 1'b0;
    bus.lo_vld   = 1'b0;
    bus.res_rdy  = 1'b0;
    q_model      = '0;
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    run_txn(32'd510, 16'h0000, 16'h0002, 4, 1'b0);
    run_txn(32'd1000, 16'h0000, 16'h0003, 0, 1'b1);
    run_txn(32'd100, 16'h0000, 16'h0001, 1, 1'b0);
    run_txn(32'hFFFF_FFFF, 16'h0101, 16'h0101, 0, 1'b0);
    run_txn(32'hFFFF_FFFF, 16'h0000, 16'h0000, 2, 1'b0);

    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      q = x / 255 + ((i % 2 == 1) ? 32'd1 : 32'd0);
      run_txn(x, q[31:16], q[15:0], i, 1'b0);
    end

    // reset in GET_LO discards the partial transaction
    bus.start    = 1'b1;
    bus.dividend = 32'd777;
    tick();
    bus.start  = 1'b0;
    bus.din    = 16'h00AB;
    bus.hi_vld = 1'b1;
    tick();
    bus.hi_vld = 1'b0;
    check_eq("get_lo_busy", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    q_model = '0;
    check_zero("rst_mid");
    bus.din    = 16'h1234;
    bus.lo_vld = 1'b1;
    tick();
    bus.lo_vld = 1'b0;
    check_zero("lo_after_rst");
    tick();
    check_eq("idle_stays", bus.busy, 1'b0);

    run_txn(32'd1000, 16'h0000, 16'h0003, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
